// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: core-side request and
// response structs, FSM states and byte-lane helpers.
package dmem_responder_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  typedef enum logic [1:0] {
    DMEM_RESP_IDLE,
    DMEM_RESP_WAIT,
    DMEM_RESP_RESP
  } dmem_resp_state_e;

  function automatic logic [31:0] byte_lane_zext(input logic [31:0] word,
                                                 input logic [1:0]  lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return {24'h0, b};
  endfunction

  function automatic logic [3:0] byte_lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised backing store: synchronous byte-lane write, combinational read.
module dmem_array #(
  parameter int addr_width_p = 10
) (
  input  logic                    clk,
  input  logic [3:0]              wen,
  input  logic [addr_width_p-1:0] addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata
);

  logic [31:0] mem [2**addr_width_p];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request in IDLE, commits stores and reads
// loads at acceptance, waits latency_p cycles, then holds the response until yumi.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2
) (
  input  logic     clk,
  input  logic     n_reset,
  input  mem_in_s  to_mem_i,
  input  logic [31:0] addr_i,
  output mem_out_s from_mem_o,
  output logic     busy_o
);

  localparam int cnt_w_lp = (latency_p < 2) ? 1 : $clog2(latency_p + 1);
  localparam logic [cnt_w_lp-1:0] lat_lp = cnt_w_lp'(latency_p);

  dmem_resp_state_e      state_q, state_d;
  logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  accept, req_yumi, resp_valid;
  logic [3:0]            arr_wen;
  logic [31:0]           arr_wdata, arr_rdata;
  logic [1:0]            lane;
  logic                  unused_addr;

  assign lane        = addr_i[1:0];
  assign unused_addr = ^{addr_i[31:addr_width_p+2]};

  // Byte stores replicate the low byte to every lane; the lane mask picks one.
  assign arr_wdata = to_mem_i.byte_not_word ? {4{to_mem_i.write_data[7:0]}}
                                            : to_mem_i.write_data;
  assign arr_wen   = (accept && to_mem_i.wen)
                   ? (to_mem_i.byte_not_word ? byte_lane_mask(lane) : 4'hF)
                   : 4'h0;

  dmem_array #(.addr_width_p(addr_width_p)) u_array (
    .clk   (clk),
    .wen   (arr_wen),
    .addr  (addr_i[addr_width_p+1:2]),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    accept     = 1'b0;
    req_yumi   = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      DMEM_RESP_IDLE: begin
        req_yumi = to_mem_i.valid;
        if (to_mem_i.valid) begin
          accept  = 1'b1;
          cnt_d   = lat_lp;
          rdata_d = to_mem_i.wen           ? 32'h0
                  : to_mem_i.byte_not_word ? byte_lane_zext(arr_rdata, lane)
                  :                          arr_rdata;
          state_d = (latency_p > 0) ? DMEM_RESP_WAIT : DMEM_RESP_RESP;
        end
      end
      DMEM_RESP_WAIT: begin
        cnt_d = cnt_q - cnt_w_lp'(1);
        if (cnt_q <= cnt_w_lp'(1)) state_d = DMEM_RESP_RESP;
      end
      DMEM_RESP_RESP: begin
        resp_valid = 1'b1;
        if (to_mem_i.yumi) state_d = DMEM_RESP_IDLE;
      end
      default: state_d = DMEM_RESP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= DMEM_RESP_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign from_mem_o = '{read_data: rdata_q, valid: resp_valid, yumi: req_yumi};
  assign busy_o     = (state_q != DMEM_RESP_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: latency-2 and latency-0 instances.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        sel = 1'b0;
  mem_in_s     req = '0;
  mem_in_s     req_a, req_b;
  logic [31:0] addr = '0;
  mem_out_s    rsp_a, rsp_b, rsp;
  logic        busy_a, busy_b, busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  assign req_a = sel ? '0 : req;
  assign req_b = sel ? req : '0;
  assign rsp   = sel ? rsp_b : rsp_a;
  assign busy  = sel ? busy_b : busy_a;

  dmem_responder #(.addr_width_p(10), .latency_p(2)) u_dut (
    .clk(clk), .n_reset(n_reset), .to_mem_i(req_a), .addr_i(addr),
    .from_mem_o(rsp_a), .busy_o(busy_a));

  dmem_responder #(.addr_width_p(10), .latency_p(0)) u_dut0 (
    .clk(clk), .n_reset(n_reset), .to_mem_i(req_b), .addr_i(addr),
    .from_mem_o(rsp_b), .busy_o(busy_b));

  // Present a request in the current IDLE cycle, expect yumi, push expected data.
  task automatic issue(input logic w, input logic b, input logic [31:0] a,
                       input logic [31:0] wd, input logic keep,
                       input logic [31:0] exp);
    req.valid = 1'b1; req.wen = w; req.byte_not_word = b;
    req.write_data = wd; req.yumi = 1'b0; addr = a;
    #1;
    n_cmp++;
    if (rsp.yumi !== 1'b1) begin
      n_err++; $display("FAIL req_yumi addr=%h: got %b expected 1", a, rsp.yumi);
    end
    exp_q.push_back(exp);
    @(posedge clk); #1;
    if (!keep) req.valid = 1'b0;
  endtask

  // Wait for response, check latency/data, hold 'hold' cycles, then acknowledge.
  task automatic complete(input int lat, input int hold);
    int n = 0;
    logic [31:0] exp;
    while (rsp.valid !== 1'b1 && n < 20) begin
      n_cmp++;
      if (rsp.yumi !== 1'b0) begin
        n_err++; $display("FAIL wait_no_yumi: got %b expected 0", rsp.yumi);
      end
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (n != lat) begin
      n_err++; $display("FAIL rsp_latency: got %0d cycles expected %0d", n, lat);
    end
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL scoreboard_empty: got 0 entries expected 1");
      exp = 32'h0;
    end else exp = exp_q.pop_front();
    n_cmp++;
    if (rsp.read_data !== exp) begin
      n_err++; $display("FAIL rsp_data: got %h expected %h", rsp.read_data, exp);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rsp.valid !== 1'b1 || rsp.read_data !== exp || rsp.yumi !== 1'b0) begin
        n_err++;
        $display("FAIL rsp_hold[%0d]: got v=%b d=%h y=%b expected v=1 d=%h y=0",
                 h, rsp.valid, rsp.read_data, rsp.yumi, exp);
      end
    end
    req.yumi = 1'b1;
    #1;
    n_cmp++;
    if (rsp.yumi !== 1'b0) begin
      n_err++; $display("FAIL yumi_cycle_accept: got %b expected 0", rsp.yumi);
    end
    @(posedge clk); #1;
    req.yumi = 1'b0;
    n_cmp++;
    if (rsp.valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rsp_release: got v=%b busy=%b expected 0/0", rsp.valid, busy);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_a !== '0 || busy_a !== 1'b0) begin
      n_err++; $display("FAIL reset_a: got rsp=%h busy=%b expected 0/0", rsp_a, busy_a);
    end
    n_cmp++;
    if (rsp_b !== '0 || busy_b !== 1'b0) begin
      n_err++; $display("FAIL reset_b: got rsp=%h busy=%b expected 0/0", rsp_b, busy_b);
    end
  endtask

  task automatic test_word_rw;
    sel = 1'b0;
    issue(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    complete(2, 0);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    complete(2, 5);
  endtask

  task automatic test_byte;
    sel = 1'b0;
    issue(1'b1, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h0);
    complete(2, 0);
    issue(1'b1, 1'b1, 32'h13, 32'h5A5A5AAA, 1'b0, 32'h0);
    complete(2, 0);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hAA223344);
    complete(2, 0);
    issue(1'b0, 1'b1, 32'h13, 32'h0, 1'b0, 32'h000000AA);
    complete(2, 0);
    issue(1'b0, 1'b1, 32'h11, 32'h0, 1'b0, 32'h00000033);
    complete(2, 0);
  endtask

  task automatic test_lat0;
    sel = 1'b1;
    issue(1'b1, 1'b0, 32'h20, 32'h12345678, 1'b0, 32'h0);
    complete(0, 0);
    issue(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678);
    complete(0, 0);
    issue(1'b0, 1'b1, 32'h22, 32'h0, 1'b0, 32'h00000034);
    complete(0, 1);
    sel = 1'b0;
  endtask

  task automatic test_valid_held;
    sel = 1'b0;
    issue(1'b1, 1'b0, 32'h44, 32'h55555555, 1'b0, 32'h0);
    complete(2, 0);
    issue(1'b1, 1'b0, 32'h40, 32'h00000001, 1'b1, 32'h0);
    req.write_data = 32'hBAD0BAD0; addr = 32'h44;
    complete(2, 2);
    issue(1'b0, 1'b0, 32'h44, 32'h0, 1'b0, 32'h55555555);
    complete(2, 0);
    issue(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h00000001);
    complete(2, 0);
  endtask

  task automatic test_reset_in_wait;
    sel = 1'b0;
    issue(1'b1, 1'b0, 32'h80, 32'hCAFEF00D, 1'b0, 32'h0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL wait_busy: got %b expected 1", busy);
    end
    n_reset = 1'b0;
    #1;
    n_cmp++;
    if (rsp !== '0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_in_wait: got rsp=%h busy=%b expected 0/0", rsp, busy);
    end
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (rsp.valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle: got v=%b busy=%b expected 0/0", rsp.valid, busy);
    end
    issue(1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 32'hCAFEF00D);
    complete(2, 0);
  endtask

  task automatic test_wrap;
    sel = 1'b0;
    issue(1'b1, 1'b0, 32'h1000, 32'h0BADF00D, 1'b0, 32'h0);
    complete(2, 0);
    issue(1'b0, 1'b0, 32'h0000, 32'h0, 1'b0, 32'h0BADF00D);
    complete(2, 0);
    issue(1'b0, 1'b0, 32'hFFFF_F010, 32'h0, 1'b0, 32'hAA223344);
    complete(2, 0);
  endtask

  initial begin
    test_reset;
    test_word_rw;
    test_byte;
    test_lat0;
    test_valid_held;
    test_reset_in_wait;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
